// File: rtl/fetch_unit.sv
// RV32I instruction fetch stage: owns the PC, issues credit-limited requests to
// instruction memory, buffers in-order responses and drives the IF/ID register.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] redirectPc,
    output logic        imemReqValid,
    input  logic        imemReqReady,
    output logic [31:0] imemReqAddr,
    input  logic        imemRespValid,
    input  logic [31:0] imemRespData,
    output logic        ifidValid,
    output logic [31:0] ifidInstr,
    output logic [31:0] ifidPc
);
    localparam int          CW  = $clog2(BUF_DEPTH + 1);
    localparam int          PW  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_resp_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_discard;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [31:0]   r_buf_pc    [BUF_DEPTH];
    logic [31:0]   r_buf_instr [BUF_DEPTH];
    logic          r_ifid_valid;
    logic [31:0]   r_ifid_instr;
    logic [31:0]   r_ifid_pc;

    logic w_credit;
    logic w_req_fire;
    logic w_resp_ok;
    logic w_resp_live;
    logic w_buf_empty;
    logic w_push;
    logic w_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Credits cover both in-flight requests and buffered entries, so every
    // accepted response is guaranteed a slot.
    assign w_credit     = (32'(r_outstanding) + 32'(r_count)) < 32'(BUF_DEPTH);
    assign imemReqValid = !rst && !flush && w_credit;
    assign imemReqAddr  = r_fetch_pc;
    assign w_req_fire   = imemReqValid && imemReqReady;

    // A response with nothing outstanding is a protocol violation and is ignored.
    assign w_resp_ok    = imemRespValid && (r_outstanding != '0);
    assign w_resp_live  = w_resp_ok && (r_discard == '0);
    assign w_buf_empty  = (r_count == '0);
    assign w_push       = !rst && !flush && w_resp_live && (stall || !w_buf_empty);
    assign w_pop        = !rst && !flush && !stall && !w_buf_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf_pc[r_tail]    <= r_resp_pc;
            r_buf_instr[r_tail] <= imemRespData;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_count       <= '0;
            r_head        <= '0;
            r_tail        <= '0;
            r_ifid_valid  <= 1'b0;
            r_ifid_instr  <= NOP;
            r_ifid_pc     <= RESET_PC;
        end else if (flush) begin
            // Everything still in flight after this cycle's response is stale.
            r_fetch_pc    <= redirectPc;
            r_resp_pc     <= redirectPc;
            r_outstanding <= r_outstanding - CW'(w_resp_ok);
            r_discard     <= r_outstanding - CW'(w_resp_ok);
            r_count       <= '0;
            r_head        <= '0;
            r_tail        <= '0;
            r_ifid_valid  <= 1'b0;
        end else begin
            r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(w_resp_ok);
            r_count       <= r_count + CW'(w_push) - CW'(w_pop);
            if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_resp_ok && (r_discard != '0)) begin
                r_discard <= r_discard - CW'(1);
            end
            if (w_resp_live) begin
                r_resp_pc <= r_resp_pc + 32'd4;
            end
            if (w_push) begin
                r_tail <= next_ptr(r_tail);
            end
            if (w_pop) begin
                r_head <= next_ptr(r_head);
            end
            if (!stall) begin
                if (!w_buf_empty) begin
                    r_ifid_valid <= 1'b1;
                    r_ifid_pc    <= r_buf_pc[r_head];
                    r_ifid_instr <= r_buf_instr[r_head];
                end else if (w_resp_live) begin
                    r_ifid_valid <= 1'b1;
                    r_ifid_pc    <= r_resp_pc;
                    r_ifid_instr <= imemRespData;
                end else begin
                    r_ifid_valid <= 1'b0;
                end
            end
        end
    end

    assign ifidValid = r_ifid_valid;
    assign ifidInstr = r_ifid_instr;
    assign ifidPc    = r_ifid_pc;

endmodule
